// File: rtl/ssd_instr_arbiter.sv
// N-channel round-robin / READ-first arbiter feeding an output FIFO of SSD instruction
// records, each tagged with its source channel and a global sequence number.
module ssd_instr_arbiter #(
    parameter int N_CH                = 4,
    parameter int HASH_WIDTH          = 256,
    parameter int LBA_WIDTH           = 32,
    parameter int DATA_NODE_IDX_WIDTH = 32,
    parameter int NODE_IDX_WIDTH      = 32,
    parameter int FIFO_DEPTH          = 8,
    parameter int SEQ_W               = 16,
    parameter int PRIO_MODE           = 0,
    // derived widths, leave at their defaults
    parameter int INSTR_W = HASH_WIDTH + 3*LBA_WIDTH + DATA_NODE_IDX_WIDTH + NODE_IDX_WIDTH + 2,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int CNT_W   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [N_CH*INSTR_W-1:0] in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [CH_W-1:0]         out_ch,
    output logic [SEQ_W-1:0]        out_seq,
    output logic [CNT_W-1:0]        level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = INSTR_W + CH_W + SEQ_W;
    localparam logic [1:0] OP_READ = 2'd2;

    logic [CH_W-1:0]    last_grant_reg;
    logic [SEQ_W-1:0]   seq_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   level_reg;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    logic [N_CH-1:0]    is_read;
    logic [N_CH-1:0]    above_last;
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    masked;
    logic [N_CH-1:0]    pick;
    logic [N_CH-1:0]    first;
    logic [N_CH-1:0]    grant;
    logic [CH_W-1:0]    grant_idx;
    logic [INSTR_W-1:0] push_instr;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               push;
    logic               pop;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign is_read[gi]    = in_valid[gi] && (in_instr[gi*INSTR_W +: 2] == OP_READ);
        assign above_last[gi] = (32'(gi) > 32'(last_grant_reg));
    end

    // Rotating priority: prefer requesters above last_grant, else wrap to the lowest one.
    assign req    = (PRIO_MODE == 1 && (|is_read)) ? is_read : in_valid;
    assign masked = req & above_last;
    assign pick   = (|masked) ? masked : req;
    assign first  = pick & (~pick + N_CH'(1));

    assign full      = (level_reg == CNT_W'(FIFO_DEPTH));
    assign grant     = (full || rst) ? '0 : first;
    assign in_ready  = grant;
    assign push      = |grant;
    assign out_valid = (level_reg != '0);
    assign pop       = out_valid && out_ready;
    assign level     = level_reg;

    always_comb begin
        grant_idx  = '0;
        push_instr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (first[i]) begin
                grant_idx  = CH_W'(i);
                push_instr = in_instr[i*INSTR_W +: INSTR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {push_instr, grant_idx, seq_reg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= CH_W'(N_CH - 1);
            seq_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
                last_grant_reg <= grant_idx;
                seq_reg        <= seq_reg + SEQ_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                level_reg <= level_reg + CNT_W'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - CNT_W'(1);
            end
        end
    end

    assign head      = mem[rd_ptr_reg];
    assign out_instr = head[ENTRY_W-1 -: INSTR_W];
    assign out_ch    = head[SEQ_W +: CH_W];
    assign out_seq   = head[SEQ_W-1:0];

endmodule

// File: tb/tb_ssd_instr_arbiter.sv
// Bench for ssd_instr_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model. Instance a: round-robin, 16-bit seq; instance b: READ-first, 4-bit seq.
module tb_ssd_instr_arbiter;

    localparam int N_CH  = 4;
    localparam int HW    = 16;
    localparam int LW    = 8;
    localparam int DW    = 8;
    localparam int NW    = 8;
    localparam int DEPTH = 8;
    localparam int IW    = HW + 3*LW + DW + NW + 2;
    localparam int NRAND = 10000;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [1:0]    ch;
        logic [15:0]   seq;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [N_CH-1:0]    a_valid, a_ready, b_valid, b_ready;
    logic [IW-1:0]      a_src [N_CH];
    logic [IW-1:0]      b_src [N_CH];
    logic [N_CH*IW-1:0] a_bus, b_bus;
    logic               a_out_valid, a_out_ready, b_out_valid, b_out_ready;
    logic [IW-1:0]      a_out_instr, b_out_instr;
    logic [1:0]         a_out_ch, b_out_ch;
    logic [15:0]        a_out_seq;
    logic [3:0]         b_out_seq;
    logic [3:0]         a_level, b_level;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_bus
        assign a_bus[gi*IW +: IW] = a_src[gi];
        assign b_bus[gi*IW +: IW] = b_src[gi];
    end

    ssd_instr_arbiter #(.N_CH(N_CH), .HASH_WIDTH(HW), .LBA_WIDTH(LW), .DATA_NODE_IDX_WIDTH(DW),
        .NODE_IDX_WIDTH(NW), .FIFO_DEPTH(DEPTH), .SEQ_W(16), .PRIO_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_instr(a_bus),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
        .out_ch(a_out_ch), .out_seq(a_out_seq), .level(a_level));

    ssd_instr_arbiter #(.N_CH(N_CH), .HASH_WIDTH(HW), .LBA_WIDTH(LW), .DATA_NODE_IDX_WIDTH(DW),
        .NODE_IDX_WIDTH(NW), .FIFO_DEPTH(DEPTH), .SEQ_W(4), .PRIO_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_instr(b_bus),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_ch(b_out_ch), .out_seq(b_out_seq), .level(b_level));

    function automatic logic [IW-1:0] mk(input logic [1:0] op);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {r[IW-1:2], op};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_valid = '0; b_valid = '0;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = '1; b_valid = '1;
        for (int c = 0; c < N_CH; c++) begin a_src[c] = mk(2'd0); b_src[c] = mk(2'd0); end
        @(negedge clk); #1;
        checks++; if (a_ready !== 4'b0000) $display("FAIL reset_in_ready got %b expected 0000", a_ready); else passed++;
        checks++; if (a_level !== 4'd0) $display("FAIL reset_level got %0d expected 0", a_level); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", a_out_valid); else passed++;
        checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid got %b expected 0", b_out_valid); else passed++;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (a_ready !== 4'b0001) $display("FAIL reset_first_grant_a got %b expected 0001", a_ready); else passed++;
        checks++; if (b_ready !== 4'b0001) $display("FAIL reset_first_grant_b got %b expected 0001", b_ready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_rr_order();
        logic [IW-1:0] v [N_CH];
        logic [N_CH-1:0] seen;
        do_reset();
        a_out_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) begin v[c] = mk(2'd0); a_src[c] = v[c]; end
        a_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            seen = a_ready;
            checks++; if (a_ready !== ((k < 4) ? 4'(1 << k) : 4'b0)) $display("FAIL rr_grant cycle %0d got %b expected %b", k, a_ready, (k < 4) ? 4'(1 << k) : 4'b0); else passed++;
            if (k == 0) begin
                checks++; if (a_out_valid !== 1'b0) $display("FAIL rr_first_latency got %b expected 0", a_out_valid); else passed++;
            end else begin
                checks++; if (a_out_valid !== 1'b1) $display("FAIL rr_out_valid cycle %0d got %b expected 1", k, a_out_valid); else passed++;
                checks++; if (a_out_ch !== 2'(k-1)) $display("FAIL rr_out_ch got %0d expected %0d", a_out_ch, k-1); else passed++;
                checks++; if (a_out_seq !== 16'(k-1)) $display("FAIL rr_out_seq got %0d expected %0d", a_out_seq, k-1); else passed++;
                checks++; if (a_out_instr !== v[k-1]) $display("FAIL rr_out_instr got %h expected %h", a_out_instr, v[k-1]); else passed++;
            end
            @(negedge clk);
            a_valid = a_valid & ~seen;
        end
    endtask

    task automatic test_full();
        logic [IW-1:0] v [10];
        int idx, ndel;
        logic got;
        do_reset();
        for (int i = 0; i < 10; i++) v[i] = mk(2'($urandom));
        idx = 0; ndel = 0;
        a_src[1] = v[0]; a_valid[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1; got = a_ready[1];
            @(negedge clk);
            if (got) begin
                idx++;
                if (idx < 10) a_src[1] = v[idx]; else a_valid[1] = 1'b0;
            end
        end
        #1;
        checks++; if (idx !== 8) $display("FAIL full_accepted got %0d expected 8", idx); else passed++;
        checks++; if (a_level !== 4'd8) $display("FAIL full_level got %0d expected 8", a_level); else passed++;
        checks++; if (a_ready[1] !== 1'b0) $display("FAIL full_in_ready got %b expected 0", a_ready[1]); else passed++;
        @(negedge clk);
        a_out_ready = 1'b1;
        for (int j = 0; j < 40 && ndel < 10; j++) begin
            #1; got = a_ready[1];
            if (j == 0) begin
                checks++; if (got !== 1'b0) $display("FAIL full_pop_no_push got %b expected 0", got); else passed++;
            end
            if (j == 1) begin
                checks++; if (got !== 1'b1) $display("FAIL full_push_resume got %b expected 1", got); else passed++;
            end
            if (a_out_valid) begin
                checks++; if (a_out_seq !== 16'(ndel)) $display("FAIL full_out_seq got %0d expected %0d", a_out_seq, ndel); else passed++;
                checks++; if (a_out_instr !== v[ndel]) $display("FAIL full_out_instr got %h expected %h", a_out_instr, v[ndel]); else passed++;
                ndel++;
            end
            @(negedge clk);
            if (got) begin
                idx++;
                if (idx < 10) a_src[1] = v[idx]; else a_valid[1] = 1'b0;
            end
        end
        checks++; if (ndel !== 10) $display("FAIL full_delivered got %0d expected 10", ndel); else passed++;
        a_out_ready = 1'b0;
    endtask

    task automatic test_prio();
        int ea [3] = '{0, 2, 3};
        int eb [3] = '{2, 3, 0};
        int ga [3], gb [3];
        int na, nb;
        logic [N_CH-1:0] ra, rb;
        do_reset();
        na = 0; nb = 0;
        a_src[0] = mk(2'd0); a_src[2] = mk(2'd2); a_src[3] = mk(2'd2);
        b_src[0] = a_src[0]; b_src[2] = a_src[2]; b_src[3] = a_src[3];
        a_valid = 4'b1101; b_valid = 4'b1101;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1; ra = a_ready; rb = b_ready;
            for (int c = 0; c < N_CH; c++) begin
                if (ra[c] && na < 3) begin ga[na] = c; na++; end
                if (rb[c] && nb < 3) begin gb[nb] = c; nb++; end
            end
            @(negedge clk);
            a_valid = a_valid & ~ra; b_valid = b_valid & ~rb;
        end
        checks++; if (na !== 3) $display("FAIL prio_rr_count got %0d expected 3", na); else passed++;
        checks++; if (nb !== 3) $display("FAIL prio_read_count got %0d expected 3", nb); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < na) begin
                checks++; if (ga[i] !== ea[i]) $display("FAIL prio_rr_order[%0d] got %0d expected %0d", i, ga[i], ea[i]); else passed++;
            end
            if (i < nb) begin
                checks++; if (gb[i] !== eb[i]) $display("FAIL prio_read_order[%0d] got %0d expected %0d", i, gb[i], eb[i]); else passed++;
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [IW-1:0] v [20];
        int idx, ndel;
        logic got;
        do_reset();
        idx = 0; ndel = 0;
        for (int i = 0; i < 20; i++) v[i] = mk(2'd0);
        b_src[0] = v[0]; b_valid[0] = 1'b1; b_out_ready = 1'b1;
        for (int k = 0; k < 60 && ndel < 20; k++) begin
            #1; got = b_ready[0];
            if (b_out_valid) begin
                checks++; if (b_out_seq !== 4'(ndel % 16)) $display("FAIL wrap_seq[%0d] got %0d expected %0d", ndel, b_out_seq, ndel % 16); else passed++;
                checks++; if (b_out_instr !== v[ndel]) $display("FAIL wrap_instr[%0d] got %h expected %h", ndel, b_out_instr, v[ndel]); else passed++;
                ndel++;
            end
            @(negedge clk);
            if (got) begin
                idx++;
                if (idx < 20) b_src[0] = v[idx]; else b_valid[0] = 1'b0;
            end
        end
        checks++; if (ndel !== 20) $display("FAIL wrap_delivered got %0d expected 20", ndel); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [IW-1:0] v0;
        int idx;
        logic got;
        do_reset();
        idx = 0;
        a_src[2] = mk(2'd1); a_valid[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1; got = a_ready[2];
            @(negedge clk);
            if (got) begin
                idx++;
                if (idx < 5) a_src[2] = mk(2'd1); else a_valid[2] = 1'b0;
            end
        end
        #1;
        checks++; if (a_level !== 4'd5) $display("FAIL midrst_level_before got %0d expected 5", a_level); else passed++;
        v0 = mk(2'd3);
        a_src[0] = v0; a_src[3] = mk(2'd3);
        a_valid = 4'b1001;
        #1 rst = 1'b1;
        #1;
        checks++; if (a_level !== 4'd0) $display("FAIL midrst_level got %0d expected 0", a_level); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b expected 0", a_out_valid); else passed++;
        checks++; if (a_ready !== 4'b0000) $display("FAIL midrst_in_ready got %b expected 0000", a_ready); else passed++;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (a_ready !== 4'b0001) $display("FAIL midrst_first_grant got %b expected 0001", a_ready); else passed++;
        @(negedge clk);
        a_valid[0] = 1'b0; #1;
        checks++; if (a_out_valid !== 1'b1) $display("FAIL midrst_out_valid_after got %b expected 1", a_out_valid); else passed++;
        checks++; if (a_out_ch !== 2'd0) $display("FAIL midrst_out_ch got %0d expected 0", a_out_ch); else passed++;
        checks++; if (a_out_seq !== 16'd0) $display("FAIL midrst_out_seq got %0d expected 0", a_out_seq); else passed++;
        checks++; if (a_out_instr !== v0) $display("FAIL midrst_out_instr got %h expected %h", a_out_instr, v0); else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        ent_t mq [$];
        ent_t e;
        int issued, delivered, m_last, g, c, base_fail;
        logic [15:0] m_seq;
        logic [N_CH-1:0] exp_rdy;
        do_reset();
        m_last = N_CH - 1; m_seq = '0; issued = 0; delivered = 0;
        base_fail = checks - passed;
        for (int cyc = 0; cyc < 60000 && delivered < NRAND; cyc++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (!a_valid[ch] && issued < NRAND && $urandom_range(1, 0) == 1) begin
                    a_src[ch] = mk(2'($urandom)); a_valid[ch] = 1'b1; issued++;
                end
            end
            a_out_ready = ($urandom_range(3, 0) != 0);
            #1;
            g = -1;
            if (mq.size() < DEPTH) begin
                for (int k = 1; k <= N_CH; k++) begin
                    c = (m_last + k) % N_CH;
                    if (g < 0 && a_valid[c]) g = c;
                end
            end
            exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
            checks++; if (a_ready !== exp_rdy) $display("FAIL rand_in_ready cyc %0d got %b expected %b", cyc, a_ready, exp_rdy); else passed++;
            checks++; if (a_level !== 4'(mq.size())) $display("FAIL rand_level cyc %0d got %0d expected %0d", cyc, a_level, mq.size()); else passed++;
            checks++; if (a_out_valid !== (mq.size() != 0)) $display("FAIL rand_out_valid cyc %0d got %b expected %b", cyc, a_out_valid, mq.size() != 0); else passed++;
            if (mq.size() != 0) begin
                e = mq[0];
                checks++; if (a_out_instr !== e.instr) $display("FAIL rand_out_instr cyc %0d got %h expected %h", cyc, a_out_instr, e.instr); else passed++;
                checks++; if (a_out_ch !== e.ch) $display("FAIL rand_out_ch cyc %0d got %0d expected %0d", cyc, a_out_ch, e.ch); else passed++;
                checks++; if (a_out_seq !== e.seq) $display("FAIL rand_out_seq cyc %0d got %0d expected %0d", cyc, a_out_seq, e.seq); else passed++;
                if (a_out_ready) begin
                    void'(mq.pop_front());
                    delivered++;
                end
            end
            if (g >= 0) begin
                mq.push_back('{a_src[g], 2'(g), m_seq});
                m_seq = m_seq + 16'd1;
                m_last = g;
            end
            @(negedge clk);
            if (g >= 0) a_valid[g] = 1'b0;
            if ((checks - passed) - base_fail > 20) break;
        end
        checks++; if (issued !== NRAND) $display("FAIL rand_issued got %0d expected %0d", issued, NRAND); else passed++;
        checks++; if (delivered !== NRAND) $display("FAIL rand_delivered got %0d expected %0d", delivered, NRAND); else passed++;
        a_out_ready = 1'b0;
        a_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = '0; b_valid = '0;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        for (int c = 0; c < N_CH; c++) begin a_src[c] = '0; b_src[c] = '0; end
        @(negedge clk);
        test_reset();
        test_rr_order();
        test_full();
        test_prio();
        test_seq_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ssd_instr_arbiter.md
# ssd_instr_arbiter

Parametrised N-channel arbiter and output queue for SSD instruction records. It merges instruction streams from several producers into one ordered stream towards the SSD command path, selecting by round-robin or READ-first priority. Each accepted instruction is tagged with its source channel and a global sequence number, then buffered in an output FIFO. Field widths match the shared SSD instruction record and are generalised through parameters.

## Interface
- N_CH, 4: number of input channels (≥2)
- HASH_WIDTH, 256: hash field width
- LBA_WIDTH, 32: ref_count / ssd_start / ssd_len width
- DATA_NODE_IDX_WIDTH, 32: ssd_node_idx width
- NODE_IDX_WIDTH, 32: node_idx width
- FIFO_DEPTH, 8: output queue entries (power of 2, ≥2)
- SEQ_W, 16: sequence tag width
- PRIO_MODE, 0: 0 = plain round-robin, 1 = READ-first round-robin
- Derived: INSTR_W = HASH_WIDTH + 3*LBA_WIDTH + DATA_NODE_IDX_WIDTH + NODE_IDX_WIDTH + 2; CH_W = max(1, clog2(N_CH)); CNT_W = clog2(FIFO_DEPTH+1)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  N_CH  per-channel instruction valid
- in_ready  out  N_CH  per-channel accept (one-hot or zero)
- in_instr  in  N_CH*INSTR_W  channel i at [i*INSTR_W +: INSTR_W]; record packed sha3_hash (MSB) … node_idx, op_code (bits [1:0])
- out_valid  out  1  queue head valid
- out_ready  in  1  consumer accept
- out_instr  out  INSTR_W  head record, unmodified
- out_ch  out  CH_W  source channel of head
- out_seq  out  SEQ_W  sequence tag of head
- level  out  CNT_W  current queue occupancy

## Operation
- op_code: WRITE=0, ERASE=1, READ=2, UPDATEHEADER=3.
- Request set R = in_valid. PRIO_MODE=1: if any requesting channel has op_code==READ, R is restricted to those channels; otherwise R = in_valid.
- Grant: when level < FIFO_DEPTH, grant the first channel in R searching cyclically from last_grant+1. No grant when R is empty or the queue is full. Full is evaluated on the registered level, so a same-cycle pop does not enable a push.
- in_ready = grant vector. It is combinationally dependent on in_valid and level. At most one bit is set.
- On grant (push): write {instr, ch, seq_ctr} at wr_ptr. Advance wr_ptr, set last_grant = channel, increment seq_ctr modulo 2^SEQ_W (wraps from 2^SEQ_W−1 to 0).
- Pop: out_valid && out_ready. Advance rd_ptr.
- level: +1 on push only, −1 on pop only, unchanged on both or neither. Pointers wrap modulo FIFO_DEPTH.
- out_valid = (level != 0). out_instr/out_ch/out_seq = entry at rd_ptr. Output fields are held stable while out_valid && !out_ready.
- Per-channel order is preserved. Global order equals grant order, and out_seq is strictly increasing modulo wrap.
- Non-granted channels must hold in_valid/in_instr (standard valid/ready). The arbiter does not drop or reorder held requests.
- Starvation: in PRIO_MODE=1 a non-READ channel may starve under continuous READ traffic. This is intended.

## Timing
- Reset values: last_grant = N_CH−1 (first search starts at channel 0), seq_ctr=0, wr_ptr=rd_ptr=0, level=0, out_valid=0, in_ready=0. out_instr/out_ch/out_seq are don't-care while out_valid=0.
- Latency: an instruction accepted at edge t appears at the output after edge t (one cycle), if the queue was empty.
- Throughput: one push and one pop per cycle. Sustained 1 instr/cycle when the consumer is always ready.
- Reset mid-operation: the queue is flushed immediately (asynchronous). Any in-flight handshake in that cycle is discarded.
- Full boundary: at level==FIFO_DEPTH, in_ready=0 for all channels even if out_ready=1. Push resumes the cycle after the pop.
- Empty boundary: a push and a pop cannot coincide at level 0, because out_valid=0.

## Test plan
- Reset, then channels 0..3 all valid with WRITE at once, out_ready=1 → grants in order 0,1,2,3, out_seq 0,1,2,3, out_ch 0,1,2,3, first out_valid one cycle after first grant.
- out_ready=0, channel 1 streams 10 instrs, FIFO_DEPTH=8 → 8 accepted, level=8, in_ready[1]=0; raise out_ready → pops in order, pushes resume the cycle after the first pop, 10 delivered, seq 0..9.
- PRIO_MODE=1, ch0 WRITE, ch2 READ, ch3 READ all valid → grants 2,3,0; with PRIO_MODE=0 the same stimulus → 0,2,3.
- SEQ_W=4, push 20 instrs → out_seq 0..15 then 0..3.
- Assert rst with level=5 mid-stream → next cycle level=0, out_valid=0; after release, the first grant goes to channel 0 with seq 0.
- Random valid/ready backpressure over 10k instrs with a scoreboard → no loss or duplication, per-channel order kept, out fields stable while stalled.
